// File: rtl/g_reg_file_sb_if.sv
// Bus bundle between the decode/dispatch/writeback stages and the register file.
interface g_reg_file_sb_if #(
  parameter int W_OPR  = 32,
  parameter int N_REGS = 32,
  parameter int W_ADDR = $clog2(N_REGS),
  parameter int W_TAG  = 4
);
  logic [W_ADDR-1:0] rs1_addr_i;
  logic [W_OPR-1:0]  rs1_data_o;
  logic              rs1_busy_o;
  logic [W_ADDR-1:0] rs2_addr_i;
  logic [W_OPR-1:0]  rs2_data_o;
  logic              rs2_busy_o;
  logic              rsv_valid_i;
  logic [W_ADDR-1:0] rsv_addr_i;
  logic [W_TAG-1:0]  rsv_tag_i;
  logic              wb_valid_i;
  logic [W_ADDR-1:0] wb_addr_i;
  logic [W_TAG-1:0]  wb_tag_i;
  logic [W_OPR-1:0]  wb_data_i;
  logic              flush_i;
  logic [W_ADDR:0]   busy_cnt_o;

  modport master (
    output rs1_addr_i, rs2_addr_i, rsv_valid_i, rsv_addr_i, rsv_tag_i,
           wb_valid_i, wb_addr_i, wb_tag_i, wb_data_i, flush_i,
    input  rs1_data_o, rs1_busy_o, rs2_data_o, rs2_busy_o, busy_cnt_o
  );

  modport slave (
    input  rs1_addr_i, rs2_addr_i, rsv_valid_i, rsv_addr_i, rsv_tag_i,
           wb_valid_i, wb_addr_i, wb_tag_i, wb_data_i, flush_i,
    output rs1_data_o, rs1_busy_o, rs2_data_o, rs2_busy_o, busy_cnt_o
  );
endinterface

// File: rtl/g_reg_file_sb.sv
// General register file with a per-register write-reservation scoreboard.
// A reservation marks the destination busy under an issue tag; only the writeback
// carrying the newest tag releases it, but every writeback updates the data.
module g_reg_file_sb #(
  parameter int W_OPR    = 32,
  parameter int N_REGS   = 32,
  parameter int W_ADDR   = $clog2(N_REGS),
  parameter int W_TAG    = 4,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  g_reg_file_sb_if.slave bus
);

  localparam logic [W_ADDR-1:0] ADDR0 = '0;

  logic [W_OPR-1:0]  data_q [N_REGS];
  logic [W_TAG-1:0]  tag_q  [N_REGS];
  logic [N_REGS-1:0] busy_q;
  logic [N_REGS-1:0] busy_nxt;
  logic [W_ADDR:0]   busy_cnt_q;
  logic [W_ADDR:0]   cnt_nxt;
  logic              rsv_en;
  logic              wb_en;
  logic              wb_match;

  // Register 0 is hard-wired when ZERO_REG is set, so its requests are dropped here.
  assign rsv_en   = bus.rsv_valid_i && !(ZERO_REG && (bus.rsv_addr_i == ADDR0));
  assign wb_en    = bus.wb_valid_i  && !(ZERO_REG && (bus.wb_addr_i  == ADDR0));
  assign wb_match = busy_q[bus.wb_addr_i] && (tag_q[bus.wb_addr_i] == bus.wb_tag_i);

  // Next busy vector: flush, then tag-matched release, then reserve (reserve wins).
  always_comb begin
    busy_nxt = bus.flush_i ? '0 : busy_q;
    if (wb_en && wb_match) busy_nxt[bus.wb_addr_i] = 1'b0;
    if (rsv_en)            busy_nxt[bus.rsv_addr_i] = 1'b1;
  end

  // Population count of the next busy vector, registered alongside it.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < N_REGS; i++) cnt_nxt = cnt_nxt + (W_ADDR+1)'(busy_nxt[i]);
  end

  // Storage update; data is written even by a stale writer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_REGS; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_nxt;
      busy_cnt_q <= cnt_nxt;
      if (wb_en)  data_q[bus.wb_addr_i] <= bus.wb_data_i;
      if (rsv_en) tag_q[bus.rsv_addr_i] <= bus.rsv_tag_i;
    end
  end

  logic [W_ADDR-1:0] rd_addr [2];
  logic [W_OPR-1:0]  rd_data [2];
  logic [1:0]        rd_busy;

  assign rd_addr[0] = bus.rs1_addr_i;
  assign rd_addr[1] = bus.rs2_addr_i;

  // Operand reads from current state, with optional forwarding of this cycle's writeback.
  always_comb begin
    rd_data = '{default: '0};
    rd_busy = '0;
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = data_q[rd_addr[p]];
      rd_busy[p] = busy_q[rd_addr[p]];
      if (BYPASS && wb_en && (bus.wb_addr_i == rd_addr[p])) begin
        rd_data[p] = bus.wb_data_i;
        rd_busy[p] = busy_q[rd_addr[p]] && (tag_q[rd_addr[p]] != bus.wb_tag_i);
      end
      if (ZERO_REG && (rd_addr[p] == ADDR0)) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end
    end
  end

  assign bus.rs1_data_o = rd_data[0];
  assign bus.rs1_busy_o = rd_busy[0];
  assign bus.rs2_data_o = rd_data[1];
  assign bus.rs2_busy_o = rd_busy[1];
  assign bus.busy_cnt_o = busy_cnt_q;

endmodule

// File: tb/tb_g_reg_file_sb.sv
// Randomized and directed bench for g_reg_file_sb against an array-based reference model.
module tb_g_reg_file_sb;
  localparam int W_OPR  = 32;
  localparam int N_REGS = 32;
  localparam int W_ADDR = 5;
  localparam int W_TAG  = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  g_reg_file_sb_if #(.W_OPR(W_OPR), .N_REGS(N_REGS), .W_ADDR(W_ADDR), .W_TAG(W_TAG)) bus ();

  g_reg_file_sb #(
    .W_OPR(W_OPR), .N_REGS(N_REGS), .W_ADDR(W_ADDR), .W_TAG(W_TAG),
    .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [W_OPR-1:0] m_data [N_REGS];
  bit               m_busy [N_REGS];
  int               m_tag  [N_REGS];

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, obs, exp, $time);
    end
  endtask

  task automatic idle();
    bus.rsv_valid_i = 1'b0;
    bus.rsv_addr_i  = '0;
    bus.rsv_tag_i   = '0;
    bus.wb_valid_i  = 1'b0;
    bus.wb_addr_i   = '0;
    bus.wb_tag_i    = '0;
    bus.wb_data_i   = '0;
    bus.flush_i     = 1'b0;
  endtask

  task automatic rsv(input int a, input int t);
    bus.rsv_valid_i = 1'b1;
    bus.rsv_addr_i  = W_ADDR'(a);
    bus.rsv_tag_i   = W_TAG'(t);
  endtask

  task automatic wb(input int a, input int t, input logic [W_OPR-1:0] d);
    bus.wb_valid_i = 1'b1;
    bus.wb_addr_i  = W_ADDR'(a);
    bus.wb_tag_i   = W_TAG'(t);
    bus.wb_data_i  = d;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_REGS; i++) begin
      m_data[i] = '0;
      m_busy[i] = 1'b0;
      m_tag[i]  = 0;
    end
  endtask

  function automatic int model_cnt();
    int n = 0;
    for (int i = 0; i < N_REGS; i++) if (m_busy[i]) n++;
    return n;
  endfunction

  // Expected read: reg 0 is zero; a same-cycle writeback is forwarded.
  task automatic exp_read(input int a, output logic [W_OPR-1:0] d, output bit b);
    int wa = int'(bus.wb_addr_i);
    if (a == 0) begin
      d = '0;
      b = 1'b0;
    end else if (bus.wb_valid_i && wa == a) begin
      d = bus.wb_data_i;
      b = m_busy[a] && (m_tag[a] != int'(bus.wb_tag_i));
    end else begin
      d = m_data[a];
      b = m_busy[a];
    end
  endtask

  // Apply the clock-edge rules to the model using the inputs present at the edge.
  task automatic model_clock();
    int wa = int'(bus.wb_addr_i);
    int ra = int'(bus.rsv_addr_i);
    bit release_ok = m_busy[wa] && (m_tag[wa] == int'(bus.wb_tag_i));
    if (bus.flush_i) for (int i = 0; i < N_REGS; i++) m_busy[i] = 1'b0;
    if (bus.wb_valid_i && wa != 0) begin
      m_data[wa] = bus.wb_data_i;
      if (release_ok) m_busy[wa] = 1'b0;
    end
    if (bus.rsv_valid_i && ra != 0) begin
      m_busy[ra] = 1'b1;
      m_tag[ra]  = int'(bus.rsv_tag_i);
    end
  endtask

  // Check both read ports against the model, clock once, then check the count.
  task automatic cycle();
    logic [W_OPR-1:0] d;
    bit b;
    #2;
    exp_read(int'(bus.rs1_addr_i), d, b);
    chk("rs1_data", bus.rs1_data_o, d);
    chk("rs1_busy", bus.rs1_busy_o, b);
    exp_read(int'(bus.rs2_addr_i), d, b);
    chk("rs2_data", bus.rs2_data_o, d);
    chk("rs2_busy", bus.rs2_busy_o, b);
    @(posedge clk);
    model_clock();
    #1;
    chk("busy_cnt", bus.busy_cnt_o, model_cnt());
  endtask

  initial begin
    idle();
    bus.rs1_addr_i = '0;
    bus.rs2_addr_i = '0;
    model_reset();
    #12 reset = 1'b1;
    @(posedge clk);
    #1;

    // After reset
    bus.rs1_addr_i = 5'd5;
    bus.rs2_addr_i = 5'd31;
    #1;
    chk("rst_rs1_data", bus.rs1_data_o, 0);
    chk("rst_rs2_busy", bus.rs2_busy_o, 0);
    chk("rst_cnt", bus.busy_cnt_o, 0);
    cycle();

    // Reserve then matching writeback with bypass
    rsv(3, 2);
    cycle();
    idle();
    bus.rs1_addr_i = 5'd3;
    #1;
    chk("r3_busy", bus.rs1_busy_o, 1);
    chk("r3_cnt", bus.busy_cnt_o, 1);
    cycle();
    wb(3, 2, 32'hDEAD_BEEF);
    #1;
    chk("r3_byp_data", bus.rs1_data_o, 32'hDEAD_BEEF);
    chk("r3_byp_busy", bus.rs1_busy_o, 0);
    cycle();
    idle();
    chk("r3_cnt_after", bus.busy_cnt_o, 0);
    cycle();

    // Tag mismatch keeps the reservation
    rsv(7, 1);
    cycle();
    rsv(7, 4);
    cycle();
    idle();
    wb(7, 1, 32'h11);
    bus.rs1_addr_i = 5'd7;
    cycle();
    idle();
    #1;
    chk("r7_stale_data", bus.rs1_data_o, 32'h11);
    chk("r7_stale_busy", bus.rs1_busy_o, 1);
    cycle();
    wb(7, 4, 32'h22);
    cycle();
    idle();
    #1;
    chk("r7_data", bus.rs1_data_o, 32'h22);
    chk("r7_busy", bus.rs1_busy_o, 0);
    cycle();

    // Same-cycle reserve and writeback on r9
    rsv(9, 5);
    wb(9, 3, 32'hA5);
    cycle();
    idle();
    bus.rs1_addr_i = 5'd9;
    #1;
    chk("r9_data", bus.rs1_data_o, 32'hA5);
    chk("r9_busy", bus.rs1_busy_o, 1);
    wb(9, 5, 32'hB6);
    #1;
    chk("r9_tag5_release", bus.rs1_busy_o, 0);
    cycle();
    idle();

    // Flush with a same-cycle reserve
    rsv(1, 1); cycle();
    rsv(2, 2); cycle();
    rsv(4, 3); cycle();
    idle();
    chk("cnt3", bus.busy_cnt_o, 3);
    bus.flush_i = 1'b1;
    rsv(6, 7);
    cycle();
    idle();
    chk("flush_cnt", bus.busy_cnt_o, 1);
    bus.rs1_addr_i = 5'd6;
    bus.rs2_addr_i = 5'd4;
    #1;
    chk("r6_busy", bus.rs1_busy_o, 1);
    chk("r4_busy", bus.rs2_busy_o, 0);
    bus.rs1_addr_i = 5'd9;
    #1;
    chk("r9_data_kept", bus.rs1_data_o, 32'hB6);
    cycle();

    // Zero register
    rsv(0, 3);
    wb(0, 3, 32'hFFFF_FFFF);
    bus.rs2_addr_i = 5'd0;
    cycle();
    idle();
    #1;
    chk("r0_data", bus.rs2_data_o, 0);
    chk("r0_busy", bus.rs2_busy_o, 0);
    cycle();

    // Reset in the middle of a reservation
    rsv(10, 1);
    cycle();
    idle();
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_cnt", bus.busy_cnt_o, 0);
    bus.rs1_addr_i = 5'd10;
    #1;
    chk("mid_rst_busy", bus.rs1_busy_o, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic on a narrow address window to force collisions
    for (int n = 0; n < 800; n++) begin
      int amax = ($urandom_range(0, 7) == 0) ? N_REGS - 1 : 7;
      bus.rsv_valid_i = 1'($urandom_range(0, 1));
      bus.rsv_addr_i  = W_ADDR'($urandom_range(0, amax));
      bus.rsv_tag_i   = W_TAG'($urandom_range(0, 3));
      bus.wb_valid_i  = 1'($urandom_range(0, 1));
      bus.wb_addr_i   = W_ADDR'($urandom_range(0, amax));
      bus.wb_tag_i    = W_TAG'($urandom_range(0, 3));
      bus.wb_data_i   = W_OPR'($urandom());
      bus.flush_i     = ($urandom_range(0, 15) == 0);
      bus.rs1_addr_i  = W_ADDR'($urandom_range(0, amax));
      bus.rs2_addr_i  = ($urandom_range(0, 3) == 0) ? bus.wb_addr_i : W_ADDR'($urandom_range(0, amax));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
